r_resp_demux_1x2: RTL and testbench
===================================

# r_resp_demux_1x2

Read-response demultiplexer for the AXI interconnect datapath. It routes R-channel beats from one slave back to whichever of two masters issued the matching AR, in issue order. An in-order source tracker records the master index for each accepted AR. A one-entry output register decouples slave and master timing. It complements the request-side 2:1 select path that merges master AR traffic toward the slave.

## Interface
- DATA_W, 32: RDATA width in bits
- ID_W, 4: RID width in bits
- DEPTH, 4: maximum outstanding read bursts tracked; power of two, at least 2
- ACLK  in  1  clock; all logic on the rising edge
- ARESET  in  1  synchronous, active-high reset
- ar_push  in  1  AR handshake toward the slave completed this cycle
- ar_src  in  1  issuing master for that AR (0 = M0, 1 = M1)
- ar_full  out  1  tracker full; the upstream AR select must withhold ARVALID while high
- s_rvalid / s_rready  in / out  1 / 1  slave R handshake
- s_rdata, s_rid, s_rresp, s_rlast  in  DATA_W, ID_W, 2, 1  slave R payload
- m0_rvalid, m1_rvalid  out  1  master R valid
- m0_rready, m1_rready  in  1  master R ready
- m_rdata, m_rid, m_rresp, m_rlast  out  DATA_W, ID_W, 2, 1  shared registered payload, qualified by the mN_rvalid signals
- err  out  1  sticky protocol-error flag (see Configuration)

## Operation
- Tracker: FIFO of DEPTH 1-bit entries.
  - Push ar_src when ar_push=1 and the tracker is not full.
  - Pop the head when a beat with s_rlast=1 is accepted from the slave.
  - The head selects the destination of every beat in the current burst.
- Output register holds out_v, out_dst and the payload.
  - dst_ready = out_dst ? m1_rready : m0_rready
  - can_load = !out_v || dst_ready
  - s_rready = tracker_not_empty && can_load
- On s_rvalid && s_rready: load the payload, set out_dst = head and out_v = 1.
- Else if dst_ready: clear out_v.
- m0_rvalid = out_v && !out_dst; m1_rvalid = out_v && out_dst. Never both high.
- Push and pop in the same cycle: both take effect and the count is unchanged. This is legal even when the tracker is full, because the pop frees the slot. ar_full is computed from the registered count only, so the upstream stays blocked that cycle.
- ar_push while full with no pop in the same cycle: the push is dropped and the pointers are unchanged.
- Tracker empty: s_rready=0 and no beat is accepted.
- Pointers are log2(DEPTH)-bit and wrap naturally. count is (log2(DEPTH)+1)-bit.
- The payload passes through unmodified; the block never generates a response itself.

## Timing
- Reset values: ar_full=0, s_rready=0, m0_rvalid=0, m1_rvalid=0, m_rdata/m_rid/m_rresp/m_rlast=0, err=0. The tracker is emptied.
- ARESET mid-burst discards the tracker contents and any held beat the same edge. Outputs reach reset values in the next cycle.
- Latency: slave accept to mN_rvalid is 1 cycle.
- Throughput is 1 beat/cycle when the destination holds ready high, including back-to-back bursts to alternating masters.
- An AR pushed in cycle N can route an R beat accepted in cycle N+1 or later.
- mN_rvalid, once high, stays high with a stable payload until mN_rready is high (AXI rule).

## Configuration
- R_DEMUX_ERR_EN defined:
  - err is set on s_rvalid=1 while the tracker is empty, or on a dropped push (ar_push with full and no pop).
  - err clears only on ARESET.
- R_DEMUX_ERR_EN undefined: err is tied to 0 and no detection logic is built. Datapath behaviour is identical in both cases.

## Structure
- Package axi_demux_pkg holds:
  - RESP_W = 2
  - RESP_OKAY = 2'b00, RESP_SLVERR = 2'b10
  - typedef r_payload_t {data, id, resp, last}, parameterised through package-level defaults matching DATA_W and ID_W
- Sub-module src_fifo, a 1-bit-wide synchronous FIFO with DEPTH, push, pop, head, full and empty, implements the tracker.
- The top level contains only the output register and the steering logic.

## Test plan
- Reset: assert ARESET for 2 cycles while s_rvalid=1 -> all outputs 0, s_rready=0.
- Push src 0 then 1. Slave sends a 2-beat burst (data 0xA0, 0xA1, last on the second) then a 1-beat burst 0xB0, with both readies high -> M0 gets 0xA0/0xA1 on consecutive cycles, M1 gets 0xB0, one cycle after each slave accept.
- Backpressure: m0_rready=0 for 3 cycles while M0 holds a beat -> s_rready=0, m0_rvalid stays 1, payload stable. The next beat is accepted the cycle m0_rready rises.
- Full tracker: 4 pushes, then ar_full=1. A 5th ar_push without a pop is dropped, and err=1 when R_DEMUX_ERR_EN is defined. A push in the same cycle as an RLAST accept leaves count at 4.
- Empty tracker with s_rvalid=1 -> s_rready stays 0. err=1 only with the macro; without it err=0.
- ARESET asserted mid-burst (after beat 1 of 4) -> tracker empty and mN_rvalid=0 next cycle. A new push plus a 1-beat burst routes correctly.

Source files
------------

// File: rtl/axi_demux_pkg.sv
// Shared types and constants for the AXI read-response demux datapath.
// Contents: RESP_W, RESP_OKAY, RESP_SLVERR, payload widths and the
// r_payload_t struct describing one R beat at the default widths.
package axi_demux_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ID_W_DEF   = 4;
  localparam int RESP_W     = 2;

  localparam logic [RESP_W-1:0] RESP_OKAY   = 2'b00;
  localparam logic [RESP_W-1:0] RESP_SLVERR = 2'b10;

  typedef struct packed {
    logic [DATA_W_DEF-1:0] data;
    logic [ID_W_DEF-1:0]   id;
    logic [RESP_W-1:0]     resp;
    logic                  last;
  } r_payload_t;

endpackage

// File: rtl/src_fifo.sv
// In-order source tracker: 1-bit-wide synchronous FIFO holding the master
// index of each outstanding read burst.
// Ports: clk_i, rst_i (sync, active-high), push_i/din_i (enqueue),
// pop_i (dequeue head), head_o (oldest entry), full_o, empty_o.
// A push while full is accepted only when a pop happens the same cycle.
module src_fifo #(
  parameter int DEPTH = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic push_i,
  input  logic din_i,
  input  logic pop_i,
  output logic head_o,
  output logic full_o,
  output logic empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DEPTH-1:0] mem_q;
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rd_ptr_q];

  assign do_pop  = pop_i && !empty_o;
  // the pop frees the slot, so a full tracker can still take a push that cycle
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= din_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/r_resp_demux_1x2.sv
// Read-response demultiplexer 1 slave -> 2 masters. Routes R beats in AR
// issue order using the src_fifo tracker; a one-entry output register
// decouples slave and master handshakes.
// Ports: ACLK, ARESET (sync, active-high); ar_push/ar_src/ar_full (tracker
// side); s_r* (slave R channel); m0_rvalid/m1_rvalid, m0_rready/m1_rready
// and shared m_r* payload (master side); err (sticky protocol error).
// Optional feature: define R_DEMUX_ERR_EN to build the error detector;
// otherwise err is tied low.
module r_resp_demux_1x2
  import axi_demux_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ID_W   = 4,
  parameter int DEPTH  = 4
) (
  input  logic              ACLK,
  input  logic              ARESET,
  input  logic              ar_push,
  input  logic              ar_src,
  output logic              ar_full,
  input  logic              s_rvalid,
  output logic              s_rready,
  input  logic [DATA_W-1:0] s_rdata,
  input  logic [ID_W-1:0]   s_rid,
  input  logic [RESP_W-1:0] s_rresp,
  input  logic              s_rlast,
  output logic              m0_rvalid,
  output logic              m1_rvalid,
  input  logic              m0_rready,
  input  logic              m1_rready,
  output logic [DATA_W-1:0] m_rdata,
  output logic [ID_W-1:0]   m_rid,
  output logic [RESP_W-1:0] m_rresp,
  output logic              m_rlast,
  output logic              err
);

  logic head;
  logic full;
  logic empty;
  logic dst_ready;
  logic can_load;
  logic accept;
  logic pop;

  logic              out_v_q,   out_v_d;
  logic              out_dst_q, out_dst_d;
  logic [DATA_W-1:0] data_q,    data_d;
  logic [ID_W-1:0]   id_q,      id_d;
  logic [RESP_W-1:0] resp_q,    resp_d;
  logic              last_q,    last_d;

  src_fifo #(.DEPTH(DEPTH)) u_src_fifo (
    .clk_i   (ACLK),
    .rst_i   (ARESET),
    .push_i  (ar_push),
    .din_i   (ar_src),
    .pop_i   (pop),
    .head_o  (head),
    .full_o  (full),
    .empty_o (empty)
  );

  assign dst_ready = out_dst_q ? m1_rready : m0_rready;
  assign can_load  = !out_v_q || dst_ready;
  assign s_rready  = !empty && can_load;
  assign accept    = s_rvalid && s_rready;
  assign pop       = accept && s_rlast;
  assign ar_full   = full;

  always_comb begin
    out_v_d   = out_v_q;
    out_dst_d = out_dst_q;
    data_d    = data_q;
    id_d      = id_q;
    resp_d    = resp_q;
    last_d    = last_q;
    if (accept) begin
      out_v_d   = 1'b1;
      out_dst_d = head;
      data_d    = s_rdata;
      id_d      = s_rid;
      resp_d    = s_rresp;
      last_d    = s_rlast;
    end else if (dst_ready) begin
      out_v_d = 1'b0;
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      out_v_q   <= 1'b0;
      out_dst_q <= 1'b0;
      data_q    <= '0;
      id_q      <= '0;
      resp_q    <= RESP_OKAY;
      last_q    <= 1'b0;
    end else begin
      out_v_q   <= out_v_d;
      out_dst_q <= out_dst_d;
      data_q    <= data_d;
      id_q      <= id_d;
      resp_q    <= resp_d;
      last_q    <= last_d;
    end
  end

  assign m0_rvalid = out_v_q && !out_dst_q;
  assign m1_rvalid = out_v_q && out_dst_q;
  assign m_rdata   = data_q;
  assign m_rid     = id_q;
  assign m_rresp   = resp_q;
  assign m_rlast   = last_q;

`ifdef R_DEMUX_ERR_EN
  logic err_q, err_d;

  // beat with no outstanding AR, or an AR the tracker had to drop
  always_comb begin
    err_d = err_q;
    if ((s_rvalid && empty) || (ar_push && full && !pop)) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_r_resp_demux_1x2.sv
module tb_r_resp_demux_1x2;
  import axi_demux_pkg::*;

`ifdef R_DEMUX_ERR_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif

  logic        ACLK;
  logic        ARESET;
  logic        ar_push;
  logic        ar_src;
  logic        ar_full;
  logic        s_rvalid;
  logic        s_rready;
  logic [31:0] s_rdata;
  logic [3:0]  s_rid;
  logic [1:0]  s_rresp;
  logic        s_rlast;
  logic        m0_rvalid;
  logic        m1_rvalid;
  logic        m0_rready;
  logic        m1_rready;
  logic [31:0] m_rdata;
  logic [3:0]  m_rid;
  logic [1:0]  m_rresp;
  logic        m_rlast;
  logic        err;

  r_resp_demux_1x2 #(.DATA_W(32), .ID_W(4), .DEPTH(4)) dut (
    .ACLK      (ACLK),
    .ARESET    (ARESET),
    .ar_push   (ar_push),
    .ar_src    (ar_src),
    .ar_full   (ar_full),
    .s_rvalid  (s_rvalid),
    .s_rready  (s_rready),
    .s_rdata   (s_rdata),
    .s_rid     (s_rid),
    .s_rresp   (s_rresp),
    .s_rlast   (s_rlast),
    .m0_rvalid (m0_rvalid),
    .m1_rvalid (m1_rvalid),
    .m0_rready (m0_rready),
    .m1_rready (m1_rready),
    .m_rdata   (m_rdata),
    .m_rid     (m_rid),
    .m_rresp   (m_rresp),
    .m_rlast   (m_rlast),
    .err       (err)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  typedef struct {
    logic        dst;
    logic [31:0] data;
    logic [3:0]  id;
    logic [1:0]  resp;
    logic        last;
  } beat_t;

  beat_t exp_q[$];
  logic  src_q[$];
  int    checks   = 0;
  int    failures = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_beat(input logic [31:0] d, input logic l);
    s_rvalid = 1'b1;
    s_rdata  = d;
    s_rid    = d[3:0];
    s_rresp  = d[0] ? RESP_SLVERR : RESP_OKAY;
    s_rlast  = l;
  endtask

  // Observe handshakes at the negedge (inputs stable), then advance one edge.
  task automatic tick();
    beat_t b;
    logic  pop_now;
    @(negedge ACLK);
    if (ARESET) begin
      exp_q.delete();
      src_q.delete();
    end else begin
      chk("one_hot_valid", {m0_rvalid, m1_rvalid} == 2'b11, 1'b0);
      if ((m0_rvalid && m0_rready) || (m1_rvalid && m1_rready)) begin
        chk("beat_expected", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) begin
          b = exp_q.pop_front();
          chk("sb_dst",  m1_rvalid, b.dst);
          chk("sb_data", m_rdata,   b.data);
          chk("sb_id",   m_rid,     b.id);
          chk("sb_resp", m_rresp,   b.resp);
          chk("sb_last", m_rlast,   b.last);
        end
      end
      pop_now = 1'b0;
      if (s_rvalid && s_rready) begin
        chk("accept_tracked", src_q.size() != 0, 1'b1);
        if (src_q.size() != 0) begin
          b.dst  = src_q[0];
          b.data = s_rdata;
          b.id   = s_rid;
          b.resp = s_rresp;
          b.last = s_rlast;
          exp_q.push_back(b);
          if (s_rlast) begin
            void'(src_q.pop_front());
            pop_now = 1'b1;
          end
        end
      end
      if (ar_push && (src_q.size() < 4 || pop_now)) src_q.push_back(ar_src);
    end
    @(posedge ACLK);
    #1;
  endtask

  initial begin
    ARESET    = 1'b1;
    ar_push   = 1'b0;
    ar_src    = 1'b0;
    s_rvalid  = 1'b1;
    s_rdata   = 32'h0;
    s_rid     = 4'h0;
    s_rresp   = 2'b00;
    s_rlast   = 1'b0;
    m0_rready = 1'b1;
    m1_rready = 1'b1;

    // reset with s_rvalid high
    tick();
    tick();
    chk("rst_s_rready",  s_rready,  1'b0);
    chk("rst_m0_rvalid", m0_rvalid, 1'b0);
    chk("rst_m1_rvalid", m1_rvalid, 1'b0);
    chk("rst_m_rdata",   m_rdata,   32'h0);
    chk("rst_m_rid",     m_rid,     4'h0);
    chk("rst_m_rresp",   m_rresp,   2'b00);
    chk("rst_m_rlast",   m_rlast,   1'b0);
    chk("rst_ar_full",   ar_full,   1'b0);
    chk("rst_err",       err,       1'b0);
    ARESET   = 1'b0;
    s_rvalid = 1'b0;

    // two bursts, alternating masters, full throughput
    ar_push = 1'b1; ar_src = 1'b0; tick();
    ar_src  = 1'b1; tick();
    ar_push = 1'b0;
    drive_beat(32'hA0, 1'b0); #1;
    chk("a0_s_rready", s_rready, 1'b1);
    tick();
    chk("a0_m0_rvalid", m0_rvalid, 1'b1);
    chk("a0_data", m_rdata, 32'hA0);
    drive_beat(32'hA1, 1'b1); #1;
    chk("a1_s_rready", s_rready, 1'b1);
    tick();
    chk("a1_m0_rvalid", m0_rvalid, 1'b1);
    chk("a1_data", m_rdata, 32'hA1);
    drive_beat(32'hB0, 1'b1); #1;
    chk("b0_s_rready", s_rready, 1'b1);
    tick();
    chk("b0_m1_rvalid", m1_rvalid, 1'b1);
    chk("b0_m0_rvalid", m0_rvalid, 1'b0);
    chk("b0_data", m_rdata, 32'hB0);
    s_rvalid = 1'b0;
    tick();
    chk("idle_m1_rvalid", m1_rvalid, 1'b0);

    // backpressure from M0
    ar_push = 1'b1; ar_src = 1'b0; tick();
    ar_push = 1'b0;
    m0_rready = 1'b0;
    drive_beat(32'hC0, 1'b0);
    tick();
    drive_beat(32'hC1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_s_rready",  s_rready,  1'b0);
      chk("bp_m0_rvalid", m0_rvalid, 1'b1);
      chk("bp_data",      m_rdata,   32'hC0);
      tick();
    end
    m0_rready = 1'b1; #1;
    chk("bp_release_s_rready", s_rready, 1'b1);
    tick();
    chk("c1_m0_rvalid", m0_rvalid, 1'b1);
    chk("c1_data", m_rdata, 32'hC1);
    s_rvalid = 1'b0;
    tick();

    // beat offered with an empty tracker
    chk("pre_empty_err", err, 1'b0);
    drive_beat(32'hEE, 1'b1); #1;
    chk("empty_s_rready", s_rready, 1'b0);
    tick();
    tick();
    chk("empty_s_rready2", s_rready,  1'b0);
    chk("empty_m0_rvalid", m0_rvalid, 1'b0);
    chk("empty_m1_rvalid", m1_rvalid, 1'b0);
    chk("empty_err",       err,       ERR_EXP);
    s_rvalid = 1'b0;
    ARESET = 1'b1; tick();
    ARESET = 1'b0;
    chk("err_cleared", err, 1'b0);

    // fill the tracker, drop a push, then push+pop at full
    ar_push = 1'b1;
    ar_src = 1'b1; tick();
    ar_src = 1'b0; tick();
    ar_src = 1'b1; tick();
    chk("three_not_full", ar_full, 1'b0);
    ar_src = 1'b0; tick();
    chk("four_full", ar_full, 1'b1);
    chk("full_no_err", err, 1'b0);
    ar_src = 1'b0; tick();
    chk("drop_full", ar_full, 1'b1);
    chk("drop_err",  err,     ERR_EXP);
    ar_src = 1'b1;
    drive_beat(32'hD0, 1'b1); #1;
    chk("pushpop_s_rready", s_rready, 1'b1);
    chk("pushpop_ar_full",  ar_full,  1'b1);
    tick();
    ar_push = 1'b0;
    chk("pushpop_still_full", ar_full, 1'b1);
    chk("d0_m1_rvalid", m1_rvalid, 1'b1);
    chk("d0_data", m_rdata, 32'hD0);
    for (int i = 0; i < 4; i++) begin
      drive_beat(32'hE0 + 32'(i), 1'b1);
      tick();
    end
    s_rvalid = 1'b0;
    tick();
    chk("drained_not_full", ar_full, 1'b0);
    chk("drained_sb_empty", exp_q.size(), 0);

    // reset mid-burst
    ar_push = 1'b1; ar_src = 1'b1; tick();
    ar_push = 1'b0;
    drive_beat(32'hF0, 1'b0);
    tick();
    chk("f0_m1_rvalid", m1_rvalid, 1'b1);
    m1_rready = 1'b0;
    drive_beat(32'hF1, 1'b0);
    ARESET = 1'b1;
    tick();
    ARESET = 1'b0;
    m1_rready = 1'b1; #1;
    chk("midrst_m1_rvalid", m1_rvalid, 1'b0);
    chk("midrst_m0_rvalid", m0_rvalid, 1'b0);
    chk("midrst_s_rready",  s_rready,  1'b0);
    chk("midrst_m_rdata",   m_rdata,   32'h0);
    s_rvalid = 1'b0;
    ar_push = 1'b1; ar_src = 1'b0; tick();
    ar_push = 1'b0;
    drive_beat(32'h61, 1'b1);
    tick();
    chk("g0_m0_rvalid", m0_rvalid, 1'b1);
    chk("g0_m1_rvalid", m1_rvalid, 1'b0);
    chk("g0_data", m_rdata, 32'h61);
    chk("g0_resp", m_rresp, RESP_SLVERR);
    s_rvalid = 1'b0;
    tick();
    chk("final_m0_rvalid", m0_rvalid, 1'b0);
    chk("final_sb_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
